// File: rtl/odometry_pkg.sv
// Constants and helpers shared by the odometry blocks (pulse counter and coordinate calculator).
package odometry_pkg;

  localparam int DEFAULT_CNT_W = 8;

  // Increment by one when inc is set, sticking at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value,
                                          input logic        inc);
    logic [31:0] result;
    result = value;
    if (inc && (value != max_value)) result = value + 32'd1;
    return result;
  endfunction

endpackage

// File: rtl/wheel_pulse_counter_if.sv
// Encoder inputs and per-window count outputs of the wheel pulse counter.
interface wheel_pulse_counter_if
  import odometry_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             enable;
  logic             enc_left;
  logic             enc_right;
  logic [CNT_W-1:0] pulses_namber_left;
  logic [CNT_W-1:0] pulses_namber_right;
  logic             ready;
  logic             overflow;

  // ready is a one-cycle strobe with no back-pressure: the consumer samples the
  // counts and overflow in the cycle ready is high, and they stay stable until
  // the next window closes.
  modport master (
    input  enable, enc_left, enc_right,
    output pulses_namber_left, pulses_namber_right, ready, overflow
  );

  modport slave (
    output enable, enc_left, enc_right,
    input  pulses_namber_left, pulses_namber_right, ready, overflow
  );
endinterface

// File: rtl/pulse_debouncer.sv
// Synchronises one raw encoder line, debounces it and emits a one-cycle pulse
// on each accepted rising edge.
module pulse_debouncer #(
  parameter int DEBOUNCE = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_i,
  output logic edge_o
);

  localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          edge_q;
  logic [SW-1:0] stab_q, stab_d;

  // Any cycle where the synchronised input agrees with the accepted level
  // restarts the stability count.
  always_comb begin
    level_d = level_q;
    stab_d  = '0;
    if (sync2_q != level_q) begin
      if (stab_q == STAB_LAST) begin
        level_d = ~level_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      edge_q       <= 1'b0;
      stab_q       <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      edge_q       <= level_q & ~level_prev_q;
      stab_q       <= stab_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/wheel_pulse_counter.sv
// Counts debounced rising edges of the left/right wheel encoders over a fixed
// window and publishes the totals with a one-cycle ready strobe.
module wheel_pulse_counter
  import odometry_pkg::*;
#(
  parameter int WINDOW   = 1000,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input logic                   CLK,
  input logic                   RST,
  wheel_pulse_counter_if.master bus
);

  localparam int              TW       = $clog2(WINDOW);
  localparam logic [TW-1:0]   T_LAST   = TW'(WINDOW - 1);
  localparam logic [31:0]     CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  logic             edge_l, edge_r;
  logic [TW-1:0]    timer_q;
  logic [CNT_W-1:0] acc_l_q, acc_l_d;
  logic [CNT_W-1:0] acc_r_q, acc_r_d;
  logic             sat_l_q, sat_l_d;
  logic             sat_r_q, sat_r_d;
  logic [CNT_W-1:0] out_l_q, out_r_q;
  logic             ready_q, ovf_q;
  logic             close;

  pulse_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb_left (
    .CLK    (CLK),
    .RST    (RST),
    .raw_i  (bus.enc_left),
    .edge_o (edge_l)
  );

  pulse_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb_right (
    .CLK    (CLK),
    .RST    (RST),
    .raw_i  (bus.enc_right),
    .edge_o (edge_r)
  );

  // Next accumulator values already include this cycle's edge, so an edge on
  // the closing cycle lands in the closing window rather than being lost.
  always_comb begin
    acc_l_d = CNT_W'(sat_inc(32'(acc_l_q), CNT_MAX, edge_l));
    acc_r_d = CNT_W'(sat_inc(32'(acc_r_q), CNT_MAX, edge_r));
    sat_l_d = sat_l_q | (edge_l && (32'(acc_l_q) == CNT_MAX));
    sat_r_d = sat_r_q | (edge_r && (32'(acc_r_q) == CNT_MAX));
    close   = bus.enable && (timer_q == T_LAST);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_q <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      sat_l_q <= 1'b0;
      sat_r_q <= 1'b0;
      out_l_q <= '0;
      out_r_q <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!bus.enable) begin
      // Published results are kept while paused; the window restarts from 0.
      timer_q <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      sat_l_q <= 1'b0;
      sat_r_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= close;
      if (close) begin
        timer_q <= '0;
        out_l_q <= acc_l_d;
        out_r_q <= acc_r_d;
        ovf_q   <= sat_l_d | sat_r_d;
        acc_l_q <= '0;
        acc_r_q <= '0;
        sat_l_q <= 1'b0;
        sat_r_q <= 1'b0;
      end else begin
        timer_q <= timer_q + 1'b1;
        acc_l_q <= acc_l_d;
        acc_r_q <= acc_r_d;
        sat_l_q <= sat_l_d;
        sat_r_q <= sat_r_d;
      end
    end
  end

  assign bus.pulses_namber_left  = out_l_q;
  assign bus.pulses_namber_right = out_r_q;
  assign bus.ready               = ready_q;
  assign bus.overflow            = ovf_q;

endmodule
